mdio_reg_arbiter: RTL and testbench
===================================

Name: mdio_reg_arbiter

Overview:
- PHY-side management register file: 32 x 16-bit registers behind the MDIO receptor.
- Arbitrates access between two requesters: the MDIO receptor (write strobe plus read address) and a local device-side port used for status updates and host reads.
- Applies management semantics: read-only regions, self-clearing soft reset, and hardware event counters.
- Clocked by MDC; sits between the receptor and the PHY core logic.

Parameters:
- CTRL_RST, 16'h1140, reset value of reg 0 (control).
- STAT_RST, 16'h7949, reset value of reg 1 (status).
- PHY_ID1, 16'h0141, fixed value of reg 2.
- PHY_ID2, 16'h0CC2, fixed value of reg 3.
- RO_BASE, 16, first address of the MDIO-read-only vendor region (RO_BASE..31).

Ports:
- MDC  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ADDR  input  5  register address from receptor.
- WR_DATA  input  16  MDIO write data.
- WR_STB  input  1  one-cycle MDIO write strobe.
- MDIO_DONE  input  1  transaction-complete pulse from receptor.
- RD_DATA  output  16  read data to receptor, registered.
- LOC_REQ  input  1  local request; held until LOC_ACK.
- LOC_WE  input  1  1 = local write, 0 = local read.
- LOC_ADDR  input  5  local address.
- LOC_WDATA  input  16  local write data.
- LOC_ACK  output  1  one-cycle completion pulse.
- LOC_RDATA  output  16  local read data, valid with LOC_ACK.
- SOFT_RST  output  1  one-cycle soft-reset pulse to PHY core.

Behaviour:
- Reset (rst=0, asynchronous):
  - reg0=CTRL_RST, reg1=STAT_RST, reg2=PHY_ID1, reg3=PHY_ID2, all others 0, counters 0.
  - RD_DATA=0, LOC_RDATA=0, LOC_ACK=0, SOFT_RST=0, FSM=IDLE.
  - Reset mid-request drops the request; the requester must re-assert.
- MDIO read: RD_DATA <= reg[ADDR] every cycle (1-cycle latency); turnaround covers it.
- MDIO write (WR_STB=1):
  - Writable addresses: 0 and 4..RO_BASE-1.
  - Addresses 1..3 and RO_BASE..31: write ignored, err_cnt incremented.
- Reg 0 write:
  - Stored value is WR_DATA & 16'h7FFF, so bit 15 self-clears and reads 0.
  - If WR_DATA[15]=1, SOFT_RST=1 in the following cycle only.
- Local writes:
  - Allowed to every address except 2 and 3.
  - A local write to reg 31 clears both counters (data ignored).
- Reg 31 = {err_cnt[7:0], txn_cnt[7:0]}, hardware-owned:
  - txn_cnt increments on each rising edge of MDIO_DONE and wraps 255->0.
  - err_cnt saturates at 255.
  - A clear in the same cycle as an increment: clear wins.
- Local FSM (IDLE, WAIT, ACK):
  - IDLE: LOC_REQ=1 samples and latches LOC_WE/ADDR/WDATA.
    - If WR_STB=0, the access executes this edge -> ACK.
    - If WR_STB=1, MDIO has priority -> WAIT.
  - WAIT: executes the latched access at the first edge with WR_STB=0 -> ACK.
  - ACK: LOC_ACK=1 and LOC_RDATA valid for one cycle; LOC_REQ is ignored; -> IDLE.
  - Throughput: at most one local access per 2 cycles.
- Same-cycle collision on the same address: MDIO write lands first; the deferred local write lands the next cycle, so the local value is final.
- A local read deferred in WAIT returns post-MDIO-write data.
- MDIO accesses are never stalled and never acknowledged.

Decomposition:
- Shared package mdio_pkg holds:
  - register address constants (REG_CTRL=0, REG_STAT=1, REG_ID1=2, REG_ID2=3, REG_CNT=31);
  - reset constants;
  - FSM state encoding for IDLE/WAIT/ACK.
- Sub-module mdio_evt_counters: MDIO_DONE edge detect, wrapping txn_cnt, saturating err_cnt, clear-priority logic; output is the 16-bit reg 31 value.

Test Plan:
1. Release rst, hold ADDR=0,1,2,3 -> RD_DATA = 16'h1140, 16'h7949, 16'h0141, 16'h0CC2 one cycle after each address.
2. WR_STB with ADDR=0, WR_DATA=16'h9140 -> reg0 reads 16'h1140; SOFT_RST high exactly one cycle.
3. WR_STB with ADDR=20, WR_DATA=16'hBEEF -> reg20 stays 0; reg31 = 16'h0100. Repeat 300 times -> err_cnt = 8'hFF.
4. LOC_REQ write ADDR=5, data 16'hAAAA, in the same cycle as WR_STB ADDR=5, data 16'h5555 -> FSM passes through WAIT; LOC_ACK two cycles after the request; reg5 = 16'hAAAA.
5. 257 MDIO_DONE pulses -> txn_cnt = 8'h01. A local write to reg31 coinciding with a pulse -> reg31 = 16'h0000.
6. Assert rst while the FSM is in WAIT -> LOC_ACK stays 0; all registers return to reset values; a new LOC_REQ read of ADDR=1 returns 16'h7949 with LOC_ACK one cycle later.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared constants, types and helpers for the MDIO register arbiter
package mdio_pkg;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;
  localparam logic [4:0] REG_CNT  = 5'd31;

  localparam logic [15:0] CTRL_RST_DEF = 16'h1140;
  localparam logic [15:0] STAT_RST_DEF = 16'h7949;
  localparam logic [15:0] PHY_ID1_DEF  = 16'h0141;
  localparam logic [15:0] PHY_ID2_DEF  = 16'h0CC2;
  localparam int          RO_BASE_DEF  = 16;

  // Bit 15 of the control register is the self-clearing soft-reset bit.
  localparam logic [15:0] CTRL_WMASK = 16'h7FFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
  } loc_req_t;

  function automatic logic mdio_writable(input logic [4:0] a, input int ro_base);
    logic [31:0] ai;
    ai = {27'd0, a};
    return (a == REG_CTRL) || (ai >= 32'd4 && ai < 32'(ro_base));
  endfunction

  function automatic logic loc_writable(input logic [4:0] a);
    return (a != REG_ID1) && (a != REG_ID2) && (a != REG_CNT);
  endfunction

endpackage

// File: rtl/mdio_evt_counters.sv
// rtl/mdio_evt_counters.sv - MDIO transaction and error counters backing register 31
module mdio_evt_counters
  import mdio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdio_done,
  input  logic        err_inc,
  input  logic        clr,
  output logic [15:0] cnt_val
);

  logic       done_q;
  logic [7:0] txn_cnt;
  logic [7:0] err_cnt;

  // Clear takes priority over any increment landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      txn_cnt <= 8'd0;
      err_cnt <= 8'd0;
    end else begin
      done_q <= mdio_done;
      if (clr) begin
        txn_cnt <= 8'd0;
        err_cnt <= 8'd0;
      end else begin
        if (mdio_done && !done_q) txn_cnt <= txn_cnt + 8'd1;
        if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign cnt_val = {err_cnt, txn_cnt};

endmodule

// File: rtl/mdio_reg_arbiter.sv
// rtl/mdio_reg_arbiter.sv - 32x16 PHY management register file shared by MDIO and a local port
module mdio_reg_arbiter
  import mdio_pkg::*;
#(
  parameter logic [15:0] CTRL_RST = CTRL_RST_DEF,
  parameter logic [15:0] STAT_RST = STAT_RST_DEF,
  parameter logic [15:0] PHY_ID1  = PHY_ID1_DEF,
  parameter logic [15:0] PHY_ID2  = PHY_ID2_DEF,
  parameter int          RO_BASE  = RO_BASE_DEF
) (
  input  logic        MDC,
  input  logic        rst,
  input  logic [4:0]  ADDR,
  input  logic [15:0] WR_DATA,
  input  logic        WR_STB,
  input  logic        MDIO_DONE,
  output logic [15:0] RD_DATA,
  input  logic        LOC_REQ,
  input  logic        LOC_WE,
  input  logic [4:0]  LOC_ADDR,
  input  logic [15:0] LOC_WDATA,
  output logic        LOC_ACK,
  output logic [15:0] LOC_RDATA,
  output logic        SOFT_RST
);

  logic [15:0] regs [0:30];
  logic [1:0]  state;
  loc_req_t    lreq;
  loc_req_t    cur;
  logic        exec;
  logic        mdio_err;
  logic        cnt_clr;
  logic [15:0] cnt_val;

  function automatic logic [15:0] reg_read(input logic [4:0] a);
    case (a)
      REG_ID1: return PHY_ID1;
      REG_ID2: return PHY_ID2;
      REG_CNT: return cnt_val;
      default: return regs[a];
    endcase
  endfunction

  // A local access runs only on edges free of an MDIO write, so the two never collide.
  always_comb begin
    cur  = lreq;
    exec = 1'b0;
    if (state == ST_IDLE && LOC_REQ) begin
      cur  = '{we: LOC_WE, addr: LOC_ADDR, wdata: LOC_WDATA};
      exec = !WR_STB;
    end else if (state == ST_WAIT) begin
      exec = !WR_STB;
    end
  end

  assign mdio_err = WR_STB && !mdio_writable(ADDR, RO_BASE);
  assign cnt_clr  = exec && cur.we && (cur.addr == REG_CNT);

  mdio_evt_counters u_cnt (
    .clk       (MDC),
    .rst_n     (rst),
    .mdio_done (MDIO_DONE),
    .err_inc   (mdio_err),
    .clr       (cnt_clr),
    .cnt_val   (cnt_val)
  );

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 31; i++) regs[i] <= 16'h0000;
      regs[REG_CTRL] <= CTRL_RST;
      regs[REG_STAT] <= STAT_RST;
      RD_DATA        <= 16'h0000;
      SOFT_RST       <= 1'b0;
    end else begin
      RD_DATA  <= reg_read(ADDR);
      SOFT_RST <= WR_STB && (ADDR == REG_CTRL) && WR_DATA[15];
      if (WR_STB && mdio_writable(ADDR, RO_BASE))
        regs[ADDR] <= (ADDR == REG_CTRL) ? (WR_DATA & CTRL_WMASK) : WR_DATA;
      if (exec && cur.we && loc_writable(cur.addr))
        regs[cur.addr] <= (cur.addr == REG_CTRL) ? (cur.wdata & CTRL_WMASK) : cur.wdata;
    end
  end

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lreq      <= '0;
      LOC_ACK   <= 1'b0;
      LOC_RDATA <= 16'h0000;
    end else begin
      LOC_ACK <= 1'b0;
      case (state)
        ST_IDLE: if (LOC_REQ) begin
          lreq <= cur;
          if (exec) begin
            state     <= ST_ACK;
            LOC_ACK   <= 1'b1;
            LOC_RDATA <= reg_read(cur.addr);
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: if (exec) begin
          state     <= ST_ACK;
          LOC_ACK   <= 1'b1;
          LOC_RDATA <= reg_read(cur.addr);
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_reg_arbiter.sv
// tb/tb_mdio_reg_arbiter.sv - scoreboard bench for mdio_reg_arbiter against a register-level model
module tb_mdio_reg_arbiter;

  logic        MDC = 1'b0;
  logic        rst;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        MDIO_DONE;
  logic [15:0] RD_DATA;
  logic        LOC_REQ;
  logic        LOC_WE;
  logic [4:0]  LOC_ADDR;
  logic [15:0] LOC_WDATA;
  logic        LOC_ACK;
  logic [15:0] LOC_RDATA;
  logic        SOFT_RST;

  mdio_reg_arbiter dut (
    .MDC(MDC), .rst(rst), .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB),
    .MDIO_DONE(MDIO_DONE), .RD_DATA(RD_DATA), .LOC_REQ(LOC_REQ), .LOC_WE(LOC_WE),
    .LOC_ADDR(LOC_ADDR), .LOC_WDATA(LOC_WDATA), .LOC_ACK(LOC_ACK),
    .LOC_RDATA(LOC_RDATA), .SOFT_RST(SOFT_RST)
  );

  always #5 MDC = ~MDC;

  typedef struct {
    logic [15:0] rd;
    logic        srst;
    logic        ack;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: register contents, counters and local-request bookkeeping.
  logic [15:0] m_regs [0:31];
  int          m_txn, m_err;
  bit          m_done_q, m_busy, m_ack;
  bit          m_lwe;
  logic [4:0]  m_laddr;
  logic [15:0] m_lwdata;

  function automatic logic [15:0] mread(input logic [4:0] a);
    if (a == 5'd31) return {8'(m_err), 8'(m_txn)};
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    m_regs[0] = 16'h1140;
    m_regs[1] = 16'h7949;
    m_regs[2] = 16'h0141;
    m_regs[3] = 16'h0CC2;
    m_txn = 0; m_err = 0;
    m_done_q = 0; m_busy = 0; m_ack = 0;
  endtask

  // Predicts the outputs after the coming rising edge, then advances the model across it.
  task automatic model_edge();
    exp_t e;
    bit   req_new, exec;
    if (!rst) begin
      model_reset();
      e = '{rd: 16'h0, srst: 1'b0, ack: 1'b0, rdata: 16'h0};
      exp_q.push_back(e);
      return;
    end
    req_new = LOC_REQ && !m_ack && !m_busy;
    if (req_new) begin
      m_lwe = LOC_WE; m_laddr = LOC_ADDR; m_lwdata = LOC_WDATA;
    end
    exec = (m_busy || req_new) && !WR_STB;
    e.rd    = mread(ADDR);
    e.srst  = WR_STB && ADDR == 5'd0 && WR_DATA[15];
    e.ack   = exec;
    e.rdata = mread(m_laddr);
    m_busy  = (m_busy || req_new) && WR_STB;
    m_ack   = exec;
    if (WR_STB) begin
      if (ADDR == 5'd0) m_regs[0] = WR_DATA & 16'h7FFF;
      else if (ADDR >= 5'd4 && ADDR < 5'd16) m_regs[ADDR] = WR_DATA;
      else if (m_err < 255) m_err++;
    end
    if (MDIO_DONE && !m_done_q) m_txn = (m_txn + 1) % 256;
    m_done_q = MDIO_DONE;
    if (exec && m_lwe) begin
      if (m_laddr == 5'd31) begin
        m_err = 0; m_txn = 0;
      end else if (m_laddr != 5'd2 && m_laddr != 5'd3) begin
        m_regs[m_laddr] = (m_laddr == 5'd0) ? (m_lwdata & 16'h7FFF) : m_lwdata;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    @(negedge MDC);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge MDC) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", RD_DATA, e.rd);
      check("soft_rst", {15'd0, SOFT_RST}, {15'd0, e.srst});
      check("loc_ack", {15'd0, LOC_ACK}, {15'd0, e.ack});
      if (e.ack) check("loc_rdata", LOC_RDATA, e.rdata);
    end
  end

  task automatic idle_inputs();
    WR_STB = 0; WR_DATA = 16'h0; MDIO_DONE = 0;
    LOC_REQ = 0; LOC_WE = 0; LOC_ADDR = 5'd0; LOC_WDATA = 16'h0;
  endtask

  initial begin
    rst = 0; ADDR = 5'd0;
    idle_inputs();
    model_reset();
    @(negedge MDC); #1;
    repeat (3) tick();
    rst = 1;

    // Reset values of the ID/control/status registers.
    for (int a = 0; a < 4; a++) begin ADDR = 5'(a); tick(); end
    ADDR = 5'd0; tick();

    // Control write with the soft-reset bit set.
    WR_STB = 1; ADDR = 5'd0; WR_DATA = 16'h9140; tick();
    idle_inputs(); tick(); tick();

    // Writes into the read-only vendor region, then the error counter saturates.
    WR_STB = 1; ADDR = 5'd20; WR_DATA = 16'hBEEF; tick();
    idle_inputs(); ADDR = 5'd31; tick(); tick();
    WR_STB = 1; ADDR = 5'd20; WR_DATA = 16'hBEEF;
    repeat (299) tick();
    idle_inputs(); ADDR = 5'd20; tick(); ADDR = 5'd31; tick(); tick();

    // Same-address collision: MDIO lands first, local write is final.
    WR_STB = 1; ADDR = 5'd5; WR_DATA = 16'h5555;
    LOC_REQ = 1; LOC_WE = 1; LOC_ADDR = 5'd5; LOC_WDATA = 16'hAAAA; tick();
    WR_STB = 0; tick();
    idle_inputs(); tick(); tick(); tick();

    // Transaction counter wraps, then a local clear collides with a done pulse.
    repeat (257) begin MDIO_DONE = 1; tick(); MDIO_DONE = 0; tick(); end
    ADDR = 5'd31; tick();
    MDIO_DONE = 1; LOC_REQ = 1; LOC_WE = 1; LOC_ADDR = 5'd31; LOC_WDATA = 16'h1234; tick();
    idle_inputs(); tick(); tick();

    // Reset while the local request is parked behind an MDIO write.
    WR_STB = 1; ADDR = 5'd6; WR_DATA = 16'h0F0F;
    LOC_REQ = 1; LOC_WE = 1; LOC_ADDR = 5'd7; LOC_WDATA = 16'h7777; tick();
    rst = 0; idle_inputs(); tick(); tick();
    rst = 1; ADDR = 5'd7; tick();
    LOC_REQ = 1; LOC_WE = 0; LOC_ADDR = 5'd1; tick();
    idle_inputs(); tick(); tick();

    // Randomized mixed traffic.
    for (int c = 0; c < 2500; c++) begin
      if (m_ack || !m_busy) begin
        LOC_REQ   = ($urandom_range(2) == 0);
        LOC_WE    = 1'($urandom_range(1));
        LOC_ADDR  = ($urandom_range(1) == 0) ? 5'($urandom_range(4, 8)) : 5'($urandom_range(31));
        LOC_WDATA = 16'($urandom);
        if (LOC_WE && LOC_ADDR == 5'd0) LOC_ADDR = 5'd1;
        if (LOC_WE && LOC_ADDR == 5'd31 && $urandom_range(7) != 0) LOC_WE = 0;
      end
      WR_STB    = ($urandom_range(2) == 0);
      ADDR      = ($urandom_range(3) == 0) ? LOC_ADDR : 5'($urandom_range(31));
      WR_DATA   = 16'($urandom);
      MDIO_DONE = 1'($urandom_range(1));
      tick();
    end
    idle_inputs(); tick(); tick();

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
